ioddr_burst: RTL and testbench
==============================

Name: ioddr_burst

Overview:
- Single-clock burst sequencer sitting directly above the DDR I/O primitive on the HyperBus data lane.
- Converts command and stream handshakes into cycle-exact DDR word traffic:
  - drives the primitive's combined high/low data word, byte-mask (RWDS) and output enable;
  - captures read words qualified by the device's RWDS strobe.
- Adds behaviour the bare primitive lacks: burst length, bus turnaround, programmable read latency, write masking/underrun handling and read timeout.

Parameters:
- WIDTH, 8, pad width of the DQ lane; one DDR word is 2*WIDTH bits (high half is the rising-edge half).
- LEN_W, 8, width of burst length field; max burst 2^LEN_W words.
- LAT_W, 4, width of read latency field.
- TURN, 2, bus turnaround cycles with ddr_oe low after every burst (≥1).
- TMO, 64, read timeout in cycles without an RWDS-qualified word.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_len  in  LEN_W  burst length minus 1, in DDR words
- cmd_lat  in  LAT_W  read latency cycles after turnaround
- wr_data  in  2*WIDTH  write word
- wr_mask  in  2  per-half mask, 1 = masked
- wr_valid  in  1  write word present
- wr_ready  out  1  word consumed this cycle
- rd_data  out  2*WIDTH  captured read word
- rd_valid  out  1  rd_data valid, single-cycle pulse per word
- ddr_dat_o  out  2*WIDTH  to DDR primitive data input
- ddr_mask_o  out  2  to RWDS output path
- ddr_oe  out  1  DDR output enable
- ddr_dat_i  in  2*WIDTH  from DDR primitive data output
- ddr_rwds_i  in  1  read word qualifier
- busy  out  1  not IDLE
- underrun  out  1  pulse: write word missing
- timeout  out  1  pulse: read aborted

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE, counters = 0.
- Reset mid-burst:
  - ddr_oe drops asynchronously.
  - rd_valid is not asserted.
  - Nothing is completed.
- Registers: all outputs are registered. cmd fields are latched on cmd_valid && cmd_ready.
- Burst counter: cnt, LEN_W bits.
- States:
  - IDLE → WRITE on an accepted write command.
  - IDLE → TURN on an accepted read command; rd_pend is set.
  - WRITE: wr_ready = 1 every cycle; ddr_oe = 1 on the following cycle.
    - wr_valid high: next cycle ddr_dat_o = wr_data and ddr_mask_o = wr_mask.
    - wr_valid low: ddr_dat_o = 0, ddr_mask_o = 2'b11, underrun pulses 1 cycle.
    - cnt increments every cycle, so bus timing never stalls.
    - When cnt == len: the last word is issued, then → TURN.
  - TURN: ddr_oe = 0 for TURN cycles.
    - Write completion: then → IDLE.
    - Read (rd_pend): then → LAT (cmd_lat > 0) or → READ (cmd_lat = 0).
  - LAT: counts cmd_lat cycles, then → READ.
  - READ: ddr_oe = 0.
    - Each cycle with ddr_rwds_i = 1: rd_data = ddr_dat_i and rd_valid = 1 on the next cycle; cnt increments; timer clears.
    - After word cnt == len is captured → TURN (rd_pend cleared) → IDLE.
    - If timer reaches TMO-1 without a word: timeout pulses, remaining words are dropped, → TURN → IDLE.
- Latency and throughput:
  - Command accept to first ddr_oe = 1 word: 2 cycles.
  - Write throughput: 1 word/cycle.
  - Read capture latency: 1 cycle.
- Boundaries:
  - cmd_len = 0 gives a 1-word burst.
  - cmd_len = all-ones gives 2^LEN_W words; cnt compare, no wrap.
  - ddr_rwds_i outside READ is ignored.
  - cmd_valid while busy: held off by cmd_ready = 0.
  - underrun and timeout are never both high.

Decomposition:
- Package ioddr_pkg holds:
  - state enum (IDLE, WRITE, TURN, LAT, READ);
  - MASK_ALL = 2'b11;
  - localparam helpers for 2*WIDTH.
- One sub-module, ioddr_burst_cnt: loadable up/down counter with terminal flag, shared by the burst, turnaround, latency and timeout counters.
- The DDR primitive itself stays outside this block and is instantiated beside it.

Test Plan:
- Write, cmd_len=3, wr_valid always 1, data 0x1111..0x4444 → ddr_oe high exactly 4 cycles; ddr_dat_o sequence 1111,2222,3333,4444; mask 00; then 2 cycles oe=0, busy drops, cmd_ready=1.
- Write, cmd_len=2, wr_valid low on 2nd cycle → 2nd bus word = 0000 with mask 11; underrun single pulse; burst still 3 cycles.
- Read, cmd_len=1, cmd_lat=3, rwds pulses carry 0xABCD, 0x1234 → no capture before TURN+LAT; rd_valid twice with those values, each 1 cycle after the strobe; returns to IDLE.
- Read, cmd_len=3, rwds gaps of 5 cycles between words → 4 words captured, no timeout.
- Read, cmd_len=3, only 1 rwds word then silence → timeout pulses 64 cycles after the last word; rd_valid count = 1; IDLE afterwards.
- rst asserted mid-write, no clock edge → ddr_oe=0 and busy=0 immediately; the next command after release behaves normally.

Source files
------------

// File: rtl/ioddr_pkg.sv
// rtl/ioddr_pkg.sv - shared types and constants for the HyperBus DDR burst sequencer
// Contents: state_e (burst sequencer states), MASK_ALL (both DDR halves masked),
//           word_w() (DDR word width from pad width).
package ioddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_TURN,
    ST_LAT,
    ST_READ
  } state_e;

  localparam logic [1:0] MASK_ALL = 2'b11;

  // One DDR word carries a rising-edge half and a falling-edge half.
  function automatic int word_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/ioddr_burst_cnt.sv
// rtl/ioddr_burst_cnt.sv - loadable up/down counter with terminal-compare flag
// Ports: clk, rst (async, active high); load/load_val (load has priority over en);
//        en/up (step by one in the chosen direction); cmp (terminal value);
//        hit (count currently equals cmp).
module ioddr_burst_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare rather than wrap detect, so an all-ones length still gives 2^W steps.
  assign hit = (cnt_q == cmp);

endmodule

// File: rtl/ioddr_burst.sv
// rtl/ioddr_burst.sv - burst sequencer between command/stream handshakes and the DDR I/O primitive
// Ports: cmd_* (burst command, accepted in IDLE); wr_* (write word stream);
//        rd_data/rd_valid (captured read words); ddr_dat_o/ddr_mask_o/ddr_oe (to primitive);
//        ddr_dat_i/ddr_rwds_i (from primitive); busy/underrun/timeout (status).
//        All outputs are registered.
module ioddr_burst
  import ioddr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int LAT_W = 4,
  parameter int TURN  = 2,
  parameter int TMO   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [LAT_W-1:0]     cmd_lat,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic [1:0]           wr_mask,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [2*WIDTH-1:0]   rd_data,
  output logic                 rd_valid,
  output logic [2*WIDTH-1:0]   ddr_dat_o,
  output logic [1:0]           ddr_mask_o,
  output logic                 ddr_oe,
  input  logic [2*WIDTH-1:0]   ddr_dat_i,
  input  logic                 ddr_rwds_i,
  output logic                 busy,
  output logic                 underrun,
  output logic                 timeout
);

  localparam int DW    = word_w(WIDTH);
  localparam int TRN_W = $clog2(TURN + 1);
  localparam int PH_W  = (LAT_W > TRN_W) ? LAT_W : TRN_W;
  localparam int TM_W  = $clog2(TMO + 1);

  state_e             state_q, state_d;
  logic               rd_pend_q, rd_pend_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic               oe_q, oe_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [1:0]         mask_q, mask_d;
  logic [DW-1:0]      rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               underrun_q, underrun_d;
  logic               timeout_q, timeout_d;

  logic               b_load, b_en, b_hit;
  logic               p_load, p_en, p_hit;
  logic [PH_W-1:0]    p_val;
  logic               t_load, t_en, t_hit;

  // Burst word counter: counts up from 0 to the latched length.
  ioddr_burst_cnt #(.W(LEN_W)) u_burst_cnt (
    .clk(clk), .rst(rst), .load(b_load), .load_val('0), .en(b_en),
    .up(1'b1), .cmp(len_q), .hit(b_hit)
  );

  // Phase counter: counts down through turnaround and read latency.
  ioddr_burst_cnt #(.W(PH_W)) u_phase_cnt (
    .clk(clk), .rst(rst), .load(p_load), .load_val(p_val), .en(p_en),
    .up(1'b0), .cmp('0), .hit(p_hit)
  );

  // Read timer: cycles since READ entry or the last strobed word.
  ioddr_burst_cnt #(.W(TM_W)) u_timer_cnt (
    .clk(clk), .rst(rst), .load(t_load), .load_val('0), .en(t_en),
    .up(1'b1), .cmp(TM_W'(TMO - 1)), .hit(t_hit)
  );

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    len_d       = len_q;
    lat_d       = lat_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    busy_d      = busy_q;
    oe_d        = 1'b0;
    dat_d       = '0;
    mask_d      = 2'b00;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    timeout_d   = 1'b0;
    b_load      = 1'b0;
    b_en        = 1'b0;
    p_load      = 1'b0;
    p_val       = '0;
    p_en        = 1'b0;
    t_load      = 1'b0;
    t_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          len_d       = cmd_len;
          lat_d       = cmd_lat;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          b_load      = 1'b1;
          if (cmd_write) begin
            state_d    = ST_WRITE;
            wr_ready_d = 1'b1;
          end else begin
            state_d   = ST_TURN;
            rd_pend_d = 1'b1;
            p_load    = 1'b1;
            p_val     = PH_W'(TURN - 1);
          end
        end
      end

      ST_WRITE: begin
        // A word goes on the bus every cycle; a missing one is sent fully masked.
        oe_d = 1'b1;
        b_en = 1'b1;
        if (wr_valid) begin
          dat_d  = wr_data;
          mask_d = wr_mask;
        end else begin
          mask_d     = MASK_ALL;
          underrun_d = 1'b1;
        end
        if (b_hit) begin
          state_d    = ST_TURN;
          wr_ready_d = 1'b0;
          // One extra TURN cycle: the last word is still on the bus during the first one.
          p_load     = 1'b1;
          p_val      = PH_W'(TURN);
        end
      end

      ST_TURN: begin
        if (p_hit) begin
          if (rd_pend_q) begin
            if (lat_q != '0) begin
              state_d = ST_LAT;
              p_load  = 1'b1;
              p_val   = PH_W'(lat_q - LAT_W'(1));
            end else begin
              state_d = ST_READ;
              t_load  = 1'b1;
            end
          end else begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end
        end else begin
          p_en = 1'b1;
        end
      end

      ST_LAT: begin
        if (p_hit) begin
          state_d = ST_READ;
          t_load  = 1'b1;
        end else begin
          p_en = 1'b1;
        end
      end

      ST_READ: begin
        if (ddr_rwds_i) begin
          rd_data_d  = ddr_dat_i;
          rd_valid_d = 1'b1;
          b_en       = 1'b1;
          t_load     = 1'b1;
        end else if (t_hit) begin
          timeout_d = 1'b1;
        end else begin
          t_en = 1'b1;
        end
        // A strobe wins over an expiring timer in the same cycle.
        if ((ddr_rwds_i && b_hit) || (!ddr_rwds_i && t_hit)) begin
          state_d   = ST_TURN;
          rd_pend_d = 1'b0;
          p_load    = 1'b1;
          p_val     = PH_W'(TURN - 1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      len_q       <= '0;
      lat_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
      dat_q       <= '0;
      mask_q      <= 2'b00;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      len_q       <= len_d;
      lat_q       <= lat_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      oe_q        <= oe_d;
      dat_q       <= dat_d;
      mask_q      <= mask_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      underrun_q  <= underrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign ddr_oe     = oe_q;
  assign ddr_dat_o  = dat_q;
  assign ddr_mask_o = mask_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign underrun   = underrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ioddr_burst.sv
// tb/tb_ioddr_burst.sv - self-checking bench for ioddr_burst with a cycle-timeline reference model
module tb_ioddr_burst;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int LAT_W = 4;
  localparam int TURN  = 2;
  localparam int TMO   = 64;
  localparam int NC    = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_lat = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [15:0] ddr_dat_o;
  logic [1:0]  ddr_mask_o;
  logic        ddr_oe;
  logic [15:0] ddr_dat_i = '0;
  logic        ddr_rwds_i = 1'b0;
  logic        busy;
  logic        underrun;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  logic [15:0] wd[256];
  logic [1:0]  wm[256];
  bit          wv[256];
  int          gaps[$];
  logic [15:0] sd[$];

  always #5 clk = ~clk;

  ioddr_burst #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .LAT_W(LAT_W), .TURN(TURN), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_len(cmd_len), .cmd_lat(cmd_lat),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ddr_dat_o(ddr_dat_o), .ddr_mask_o(ddr_mask_o), .ddr_oe(ddr_oe),
    .ddr_dat_i(ddr_dat_i), .ddr_rwds_i(ddr_rwds_i),
    .busy(busy), .underrun(underrun), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_write(input int len, input int valid_pct);
    for (int i = 0; i <= len; i++) begin
      wd[i] = 16'($urandom);
      wm[i] = 2'($urandom);
      wv[i] = ($urandom_range(0, 99) < valid_pct);
    end
  endtask

  // Expected timeline, cycle k = k edges after the accept edge:
  // word i on the bus at cycle 2+i, TURN idle cycles after the last word, IDLE at len+TURN+3.
  task automatic run_write(input int len);
    int last;
    bit exp_oe;
    int i;
    last = len + TURN + 3;
    chk("w_pre_ready", cmd_ready, 1);
    cmd_write = 1'b1;
    cmd_len   = 8'(len);
    cmd_lat   = 4'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= last; k++) begin
      exp_oe = (k >= 2) && (k <= len + 2);
      chk("w_oe", ddr_oe, exp_oe);
      chk("w_busy", busy, k < last);
      chk("w_cmd_ready", cmd_ready, k == last);
      chk("w_wr_ready", wr_ready, (k >= 1) && (k <= len + 1));
      chk("w_rd_valid", rd_valid, 0);
      chk("w_timeout", timeout, 0);
      if (exp_oe) begin
        i = k - 2;
        chk("w_dat", ddr_dat_o, wv[i] ? wd[i] : 16'h0000);
        chk("w_mask", ddr_mask_o, wv[i] ? wm[i] : 2'b11);
        chk("w_underrun", underrun, !wv[i]);
      end else begin
        chk("w_underrun_idle", underrun, 0);
      end
      if (k <= len + 1) begin
        wr_valid = wv[k-1];
        wr_data  = wd[k-1];
        wr_mask  = wm[k-1];
      end else begin
        wr_valid = 1'($urandom);
        wr_data  = 16'($urandom);
        wr_mask  = 2'($urandom);
      end
      cmd_valid  = (k < last);
      cmd_write  = 1'($urandom);
      cmd_len    = 8'($urandom);
      ddr_rwds_i = 1'($urandom);
      ddr_dat_i  = 16'($urandom);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  // gaps[i] = silent READ cycles before strobe i, sd[i] = its data.
  // A gap longer than TMO-1 cycles lets the timer expire first.
  task automatic run_read(input int len, input int lat);
    bit          strobe[NC];
    logic [15:0] sdat[NC];
    bit          erv[NC];
    logic [15:0] erd[NC];
    bit          eto[NC];
    int r0, prev, s, captured, end_e, last, nrv;
    for (int k = 0; k < NC; k++) begin
      strobe[k] = 0; sdat[k] = '0; erv[k] = 0; erd[k] = '0; eto[k] = 0;
    end
    r0 = TURN + lat + 1;
    prev = r0 - 1;
    captured = 0;
    end_e = -1;
    for (int i = 0; i < gaps.size(); i++) begin
      if (captured == len + 1) break;
      s = prev + 1 + gaps[i];
      if (s > prev + TMO) break;
      strobe[s] = 1;
      sdat[s] = sd[i];
      erv[s+1] = 1;
      erd[s+1] = sd[i];
      captured++;
      prev = s;
      if (captured == len + 1) end_e = s;
    end
    if (end_e < 0) begin
      end_e = prev + TMO;
      eto[end_e+1] = 1;
    end
    last = end_e + TURN + 1;
    chk("r_pre_ready", cmd_ready, 1);
    cmd_write = 1'b0;
    cmd_len   = 8'(len);
    cmd_lat   = 4'(lat);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    nrv = 0;
    for (int k = 1; k <= last; k++) begin
      chk("r_valid", rd_valid, erv[k]);
      if (erv[k]) chk("r_data", rd_data, erd[k]);
      chk("r_timeout", timeout, eto[k]);
      chk("r_oe", ddr_oe, 0);
      chk("r_underrun", underrun, 0);
      chk("r_busy", busy, k < last);
      chk("r_cmd_ready", cmd_ready, k == last);
      chk("r_wr_ready", wr_ready, 0);
      if (rd_valid) nrv++;
      if (k >= r0 && k <= end_e) begin
        ddr_rwds_i = strobe[k];
        ddr_dat_i  = strobe[k] ? sdat[k] : 16'($urandom);
      end else begin
        ddr_rwds_i = 1'($urandom);
        ddr_dat_i  = 16'($urandom);
      end
      cmd_valid = (k < last);
      cmd_write = 1'($urandom);
      cmd_len   = 8'($urandom);
      wr_valid  = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("r_count", nrv, captured);
    ddr_rwds_i = 1'b0;
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, lat, n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oe", ddr_oe, 0);
    chk("rst_dat", ddr_dat_o, 0);
    chk("rst_mask", ddr_mask_o, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write of four fixed words, all present.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 16'(16'h1111 * (i + 1));
      wm[i] = 2'b00;
      wv[i] = 1;
    end
    run_write(3);

    // Write with the second word missing.
    for (int i = 0; i < 3; i++) begin
      wd[i] = 16'(16'h0A0A + i);
      wm[i] = 2'b00;
      wv[i] = (i != 1);
    end
    run_write(2);

    // Read with latency 3 and fixed data.
    gaps = '{0, 2};
    sd = '{16'hABCD, 16'h1234};
    run_read(1, 3);

    // Read with five silent cycles between words.
    gaps = '{5, 5, 5, 5};
    sd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_read(3, 0);

    // Read where the device goes silent after one word.
    gaps = '{0};
    sd = '{16'h5A5A};
    run_read(3, 2);

    // A strobe on the very last cycle before the timer expires is still captured.
    gaps = '{TMO - 1, TMO - 1};
    sd = '{16'hC0DE, 16'hBEEF};
    run_read(1, 1);

    // Single-word bursts.
    fill_write(0, 100);
    run_write(0);
    gaps = '{1};
    sd = '{16'h7E57};
    run_read(0, 0);

    // Maximum-length write burst.
    fill_write(255, 90);
    run_write(255);

    // Reset in the middle of a write, between clock edges.
    fill_write(7, 100);
    cmd_write = 1'b1;
    cmd_len   = 8'd7;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = wd[k-1];
      wr_mask  = wm[k-1];
      @(posedge clk); #1;
    end
    chk("mid_oe_before_rst", ddr_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_oe", ddr_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_underrun", underrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    fill_write(5, 100);
    run_write(5);

    // Randomized mix of bursts.
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(0, 7);
        fill_write(len, 75);
        run_write(len);
      end else begin
        len = $urandom_range(0, 4);
        lat = $urandom_range(0, 5);
        gaps.delete();
        sd.delete();
        n = len + 1;
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 7) == 0) gaps.push_back(TMO + 3);
          else gaps.push_back($urandom_range(0, 6));
          sd.push_back(16'($urandom));
        end
        run_read(len, lat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
